// File: rtl/ale_frame_ctrl.sv
// Frame sequencer: regenerates sof/eol/eof from fixed geometry on an RGB stream and
// temporally smooths the per-frame atmospheric-light estimate with a shift-based IIR.
module ale_frame_ctrl #(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned A_INIT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_r,
  input  logic [7:0]  s_g,
  input  logic [7:0]  s_b,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic [7:0]  m_r,
  output logic [7:0]  m_g,
  output logic [7:0]  m_b,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  input  logic [7:0]  ale_A_r,
  input  logic [7:0]  ale_A_g,
  input  logic [7:0]  ale_A_b,
  input  logic        ale_A_valid,
  output logic [7:0]  A_r,
  output logic [7:0]  A_g,
  output logic [7:0]  A_b,
  output logic        A_upd,
  output logic [15:0] frame_cnt,
  output logic        err_short,
  output logic [15:0] drop_cnt
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {StIdle, StWaitSof, StActive} state_e;

  state_e          r_state, w_state_next;
  logic [XW-1:0]   r_x, w_x_cur, w_x_next;
  logic [YW-1:0]   r_y, w_y_cur, w_y_next;
  logic            w_xfer, w_fwd, w_drop, w_err, w_sof, w_eol, w_eof;
  logic [7:0]      r_m_r, r_m_g, r_m_b;
  logic            r_m_valid, r_m_sof, r_m_eol, r_m_eof, r_err_short;
  logic [15:0]     r_frame_cnt, r_drop_cnt;
  logic [7:0]      r_a_r, r_a_g, r_a_b;
  logic            r_a_upd, r_primed, r_loaded;

  assign s_ready = (r_state != StIdle);
  assign w_xfer  = s_valid && s_ready;

  always_comb begin
    w_state_next = r_state;
    w_fwd        = 1'b0;
    w_drop       = 1'b0;
    w_err        = 1'b0;
    w_x_cur      = r_x;
    w_y_cur      = r_y;
    unique case (r_state)
      StIdle: begin
        if (enable) w_state_next = StWaitSof;
      end
      StWaitSof: begin
        if (w_xfer) begin
          if (s_sof) begin
            w_fwd   = 1'b1;
            w_x_cur = '0;
            w_y_cur = '0;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      StActive: begin
        if (w_xfer) begin
          w_fwd = 1'b1;
          // Early sof: treat this pixel as the start of a fresh frame.
          if (s_sof && ((r_x != '0) || (r_y != '0))) begin
            w_err   = 1'b1;
            w_x_cur = '0;
            w_y_cur = '0;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    w_sof    = (w_x_cur == '0) && (w_y_cur == '0);
    w_eol    = (w_x_cur == XW'(WIDTH - 1));
    w_eof    = w_eol && (w_y_cur == YW'(HEIGHT - 1));
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_fwd) begin
      if (w_eol) begin
        w_x_next = '0;
        w_y_next = w_eof ? '0 : w_y_cur + 1'b1;
      end else begin
        w_x_next = w_x_cur + 1'b1;
        w_y_next = w_y_cur;
      end
      if (w_eof) w_state_next = enable ? StWaitSof : StIdle;
      else       w_state_next = StActive;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_y         <= '0;
      r_m_r       <= '0;
      r_m_g       <= '0;
      r_m_b       <= '0;
      r_m_valid   <= 1'b0;
      r_m_sof     <= 1'b0;
      r_m_eol     <= 1'b0;
      r_m_eof     <= 1'b0;
      r_err_short <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_m_valid   <= w_fwd;
      r_m_sof     <= w_fwd && w_sof;
      r_m_eol     <= w_fwd && w_eol;
      r_m_eof     <= w_fwd && w_eof;
      r_err_short <= w_err;
      if (w_fwd) begin
        r_m_r <= s_r;
        r_m_g <= s_g;
        r_m_b <= s_b;
      end
      if (w_fwd && w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Floor-shifted IIR step; the result always lies between old and new, clamp is defensive.
  function automatic logic [7:0] smooth(input logic [7:0] a_old, input logic [7:0] a_new);
    logic signed [9:0] d;
    logic signed [9:0] s;
    d = $signed({2'b00, a_new}) - $signed({2'b00, a_old});
    s = $signed({2'b00, a_old}) + (d >>> SMOOTH_SHIFT);
    if (s < 10'sd0)        return 8'd0;
    else if (s > 10'sd255) return 8'd255;
    else                   return s[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_r    <= A_INIT[7:0];
      r_a_g    <= A_INIT[7:0];
      r_a_b    <= A_INIT[7:0];
      r_a_upd  <= 1'b0;
      r_primed <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_a_upd <= 1'b0;
      if (ale_A_valid) begin
        if (!r_primed) begin
          // First estimate is the ALE reset default; skip it.
          r_primed <= 1'b1;
        end else if (!r_loaded) begin
          r_a_r    <= ale_A_r;
          r_a_g    <= ale_A_g;
          r_a_b    <= ale_A_b;
          r_loaded <= 1'b1;
          r_a_upd  <= 1'b1;
        end else begin
          r_a_r   <= smooth(r_a_r, ale_A_r);
          r_a_g   <= smooth(r_a_g, ale_A_g);
          r_a_b   <= smooth(r_a_b, ale_A_b);
          r_a_upd <= 1'b1;
        end
      end
    end
  end

  assign m_r       = r_m_r;
  assign m_g       = r_m_g;
  assign m_b       = r_m_b;
  assign m_valid   = r_m_valid;
  assign m_sof     = r_m_sof;
  assign m_eol     = r_m_eol;
  assign m_eof     = r_m_eof;
  assign err_short = r_err_short;
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign A_r       = r_a_r;
  assign A_g       = r_a_g;
  assign A_b       = r_a_b;
  assign A_upd     = r_a_upd;

endmodule
